pc_gen: RTL and testbench

- Parametrised program-counter generator for the core front end.
- Successor to the free-running PC register. Adds:
  - configurable address width, reset vector, step and alignment
  - valid/ready handshake toward instruction fetch
  - jump/branch redirect with a one-entry pending buffer
  - redirect marker for downstream flush
- Sits between the execute-stage redirect logic and the instruction-memory fetch port.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the program-counter generator.
//   pc_state_e       : BOOT -> RUN <-> PEND control states
//   PC_RESET_VEC_DEF : default first fetch address
//   pc_align()       : clears the low 'bits' bits of an address (up to 64-bit)
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;

    function automatic logic [63:0] pc_align(input logic [63:0] addr, input int unsigned bits);
        return addr & ~((64'd1 << bits) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_gen.sv
// pc_gen: parametrised program-counter generator for the core front end.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   pc_o              current fetch address (registered)
//   pc_valid_o        pc_o is a valid fetch request (low only while booting)
//   pc_ready_i        fetch accepts pc_o this cycle
//   pc_redirect_o     pc_o is the first address after a redirect
//   jump_en_i         single-cycle redirect request
//   jump_addr_i       redirect target (low ALIGN_BITS bits are cleared)
// Optional (macro PC_MISALIGN_CHK_EN):
//   misalign_o        one-cycle pulse after a jump with nonzero low bits
//   misalign_addr_o   raw address of the most recent misaligned jump
//
// A redirect that arrives while pc_o is stalled (valid & ~ready) is parked in
// a one-entry buffer so pc_o never changes under a pending request; the newest
// parked target wins.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(PC_RESET_VEC_DEF),
    parameter int unsigned       STEP       = 4,
    parameter int unsigned       ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    input  logic              pc_ready_i,
    output logic              pc_redirect_o,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i
`ifdef PC_MISALIGN_CHK_EN
    ,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o
`endif
);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic              redir_q;
    logic [ADDR_W-1:0] pend_q;

    logic              accept;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pc_step_d;

    assign accept    = valid_q & pc_ready_i;
    assign tgt       = ADDR_W'(pc_align(64'(jump_addr_i), ALIGN_BITS));
    // Wraps modulo 2^ADDR_W by construction.
    assign pc_step_d = pc_q + ADDR_W'(STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_BOOT;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            redir_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            unique case (state_q)
                PC_BOOT: begin
                    state_q <= PC_RUN;
                    valid_q <= 1'b1;
                    pc_q    <= RESET_VEC;
                end
                PC_RUN: begin
                    if (jump_en_i && (accept || !valid_q)) begin
                        pc_q    <= tgt;
                        redir_q <= 1'b1;
                    end else if (jump_en_i) begin
                        // Stalled: park the target, keep pc_o stable.
                        pend_q  <= tgt;
                        state_q <= PC_PEND;
                    end else if (accept) begin
                        pc_q    <= pc_step_d;
                        redir_q <= 1'b0;
                    end
                end
                PC_PEND: begin
                    if (accept) begin
                        // A jump in the acceptance cycle is newer than the parked one.
                        pc_q    <= jump_en_i ? tgt : pend_q;
                        redir_q <= 1'b1;
                        state_q <= PC_RUN;
                    end else if (jump_en_i) begin
                        pend_q  <= tgt;
                    end
                end
                default: state_q <= PC_BOOT;
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign pc_valid_o    = valid_q;
    assign pc_redirect_o = redir_q;

`ifdef PC_MISALIGN_CHK_EN
    logic              mis_q;
    logic [ADDR_W-1:0] mis_addr_q;
    logic              mis_d;

    // Misaligned exactly when aligning changes the address.
    assign mis_d = jump_en_i & (jump_addr_i != tgt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_q <= mis_d;
            if (mis_d) mis_addr_q <= jump_addr_i;
        end
    end

    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test-plan steps followed by randomized traffic, all
// checked against a transaction-level reference model of the PC generator.
module tb_pc_gen;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst2 = 1'b1;
    logic [AW-1:0] pc, pc2;
    logic          vld, vld2, redir, redir2;
    logic          rdy = 1'b0;
    logic          jen = 1'b0;
    logic [AW-1:0] jaddr = '0;
    logic          rdy2 = 1'b1;
    logic          jen2 = 1'b0;
    logic [AW-1:0] jaddr2 = '0;
`ifdef PC_MISALIGN_CHK_EN
    logic          mis, mis2;
    logic [AW-1:0] mis_addr, mis_addr2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .pc_o(pc), .pc_valid_o(vld), .pc_ready_i(rdy),
        .pc_redirect_o(redir), .jump_en_i(jen), .jump_addr_i(jaddr)
`ifdef PC_MISALIGN_CHK_EN
        , .misalign_o(mis), .misalign_addr_o(mis_addr)
`endif
    );

    pc_gen #(.RESET_VEC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst2), .pc_o(pc2), .pc_valid_o(vld2), .pc_ready_i(rdy2),
        .pc_redirect_o(redir2), .jump_en_i(jen2), .jump_addr_i(jaddr2)
`ifdef PC_MISALIGN_CHK_EN
        , .misalign_o(mis2), .misalign_addr_o(mis_addr2)
`endif
    );

    // Reference model: what the fetch side should observe.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_valid, m_redir, m_mis;
    logic [31:0] m_mis_addr;
    logic [31:0] m_pend[$];   // at most one parked redirect target

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_pc = 32'h0; m_valid = 0; m_redir = 0;
        m_mis = 0; m_mis_addr = 32'h0;
        m_pend.delete();
    endtask

    task automatic model_step();
        logic [31:0] t;
        bit acc;
        t   = jaddr & ~32'h3;
        acc = m_valid && rdy;
        m_mis = jen && (jaddr[1:0] != 2'b00);
        if (m_mis) m_mis_addr = jaddr;
        if (m_boot) begin
            m_boot = 0; m_valid = 1; m_pc = 32'h0;
        end else if (m_pend.size() != 0) begin
            if (acc) begin
                m_pc = jen ? t : m_pend[0];
                m_redir = 1;
                m_pend.delete();
            end else if (jen) begin
                m_pend.delete();
                m_pend.push_back(t);
            end
        end else if (jen && !acc && m_valid) begin
            m_pend.push_back(t);
        end else if (jen) begin
            m_pc = t; m_redir = 1;
        end else if (acc) begin
            m_pc = m_pc + 32'd4; m_redir = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".valid"}, 32'(vld), 32'(m_valid));
        chk({tag, ".redir"}, 32'(redir), 32'(m_redir));
`ifdef PC_MISALIGN_CHK_EN
        chk({tag, ".mis"}, 32'(mis), 32'(m_mis));
        chk({tag, ".mis_addr"}, mis_addr, m_mis_addr);
`endif
    endtask

    // Called at a negedge: drive inputs, clock once, compare at the next negedge.
    task automatic cycle(input bit j, input logic [31:0] a, input bit r, input string tag);
        jen = j; jaddr = a; rdy = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);

        // Reset-vector wrap on the second instance (ready tied high).
        rst2 = 1'b0;
        chk("wrap.boot_valid", 32'(vld2), 32'h0);
        @(negedge clk); chk("wrap.pc0", pc2, 32'hFFFF_FFF8); chk("wrap.v0", 32'(vld2), 32'h1);
        @(negedge clk); chk("wrap.pc1", pc2, 32'hFFFF_FFFC);
        @(negedge clk); chk("wrap.pc2", pc2, 32'h0000_0000); chk("wrap.redir", 32'(redir2), 32'h0);

        // Reset state of the main instance.
        chk("rst.pc", pc, 32'h0);
        chk("rst.valid", 32'(vld), 32'h0);
        chk("rst.redir", 32'(redir), 32'h0);

        rst = 1'b0;
        chk("boot.valid", 32'(vld), 32'h0);
        cycle(0, 0, 1, "seq0"); chk("seq0.exp", pc, 32'h0);
        cycle(0, 0, 1, "seq4"); chk("seq4.exp", pc, 32'h4);
        cycle(0, 0, 1, "seq8"); chk("seq8.exp", pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, "stall");
            chk("stall.pc", pc, 32'h8); chk("stall.valid", 32'(vld), 32'h1);
        end
        cycle(0, 0, 1, "seqC");  chk("seqC.exp", pc, 32'hC);
        cycle(0, 0, 1, "seq10"); chk("seq10.exp", pc, 32'h10);
        cycle(1, 32'h100, 1, "jmp");
        chk("jmp.pc", pc, 32'h100); chk("jmp.redir", 32'(redir), 32'h1);
        cycle(0, 0, 1, "jmp_next");
        chk("jmp_next.pc", pc, 32'h104); chk("jmp_next.redir", 32'(redir), 32'h0);
        cycle(1, 32'h200, 0, "pend1"); chk("pend1.pc", pc, 32'h104);
        cycle(1, 32'h300, 0, "pend2"); chk("pend2.pc", pc, 32'h104);
        cycle(0, 0, 1, "pend_acc");
        chk("pend_acc.pc", pc, 32'h300); chk("pend_acc.redir", 32'(redir), 32'h1);
        cycle(0, 0, 1, "pend_next"); chk("pend_next.pc", pc, 32'h304);
        cycle(1, 32'h1002, 1, "misj"); chk("misj.pc", pc, 32'h1000);
`ifdef PC_MISALIGN_CHK_EN
        chk("misj.pulse", 32'(mis), 32'h1); chk("misj.addr", mis_addr, 32'h1002);
`endif
        cycle(0, 0, 1, "misj_next"); chk("misj_next.pc", pc, 32'h1004);
`ifdef PC_MISALIGN_CHK_EN
        chk("misj_next.pulse", 32'(mis), 32'h0); chk("misj_next.addr", mis_addr, 32'h1002);
`endif
        cycle(1, 32'hFFFF_FFF8, 1, "wjmp");
        cycle(0, 0, 1, "wstep"); chk("wstep.pc", pc, 32'hFFFF_FFFC);
        cycle(0, 0, 1, "wwrap"); chk("wwrap.pc", pc, 32'h0);

        // Asynchronous reset while a redirect is parked.
        cycle(1, 32'h500, 0, "mpend");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        check_model("rst_hold");
        rst = 1'b0;
        chk("reboot.valid", 32'(vld), 32'h0);
        cycle(0, 0, 0, "reboot");
        chk("reboot.pc", pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            bit j, r;
            r = ($urandom_range(9) < 6);
            j = ($urandom_range(9) < 2);
            a = $urandom();
            if ($urandom_range(7) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            cycle(j, a, r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
